// File: rtl/neureka_tcdm_arbiter.sv
// neureka_tcdm_arbiter
// Shares one TCDM initiator port between N_LOAD read streams and one store
// stream. Stores have priority, bounded by an anti-starvation counter; loads
// are served round-robin. A stalled request is locked until granted. Read
// responses are routed back to the issuing load through an in-order ID FIFO.
//
// Ports
//   clk_i, rst_ni, clear_i, enable_i     : clock, async low reset, soft clear, issue enable
//   ld_req_i/ld_add_i/ld_gnt_o           : per-load read request / address / grant
//   ld_r_valid_o/ld_r_data_o             : per-load response valid, broadcast data
//   st_req_i/st_add_i/st_data_i/st_be_i  : store request
//   st_gnt_o                             : store grant
//   tcdm_*                               : shared TCDM port (wen = 1 means read)
//   busy_o                               : reads outstanding or lock held
//   err_o                                : sticky, response arrived with nothing outstanding
module neureka_tcdm_arbiter #(
  parameter int unsigned N_LOAD    = 4,
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 256,
  parameter int unsigned MAX_OUTST = 4,
  parameter int unsigned ST_BURST  = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        clear_i,
  input  logic                        enable_i,
  input  logic [N_LOAD-1:0]           ld_req_i,
  input  logic [N_LOAD-1:0][AW-1:0]   ld_add_i,
  output logic [N_LOAD-1:0]           ld_gnt_o,
  output logic [N_LOAD-1:0]           ld_r_valid_o,
  output logic [DW-1:0]               ld_r_data_o,
  input  logic                        st_req_i,
  input  logic [AW-1:0]               st_add_i,
  input  logic [DW-1:0]               st_data_i,
  input  logic [DW/8-1:0]             st_be_i,
  output logic                        st_gnt_o,
  output logic                        tcdm_req_o,
  output logic                        tcdm_wen_o,
  output logic [AW-1:0]               tcdm_add_o,
  output logic [DW-1:0]               tcdm_data_o,
  output logic [DW/8-1:0]             tcdm_be_o,
  input  logic                        tcdm_gnt_i,
  input  logic                        tcdm_r_valid_i,
  input  logic [DW-1:0]               tcdm_r_data_i,
  output logic                        busy_o,
  output logic                        err_o
);

  localparam int unsigned IW = (N_LOAD > 1) ? $clog2(N_LOAD) : 1;
  localparam int unsigned CW = $clog2(ST_BURST + 1);
  localparam int unsigned QW = $clog2(MAX_OUTST + 1);
  localparam int unsigned PW = $clog2(MAX_OUTST);

  typedef struct packed {
    logic           st;
    logic [IW-1:0]  idx;
    logic [AW-1:0]  add;
    logic [DW-1:0]  data;
    logic [DW/8-1:0] be;
  } sel_t;

  sel_t          sel, st_sel, lock_sel_q;
  logic          sel_vld, lock_q;
  logic          ld_found, full, accept, ld_acc, pop, push;
  logic [IW-1:0] ld_idx, cand, rr_q;
  logic [CW-1:0] st_cnt_q;
  logic [QW-1:0] out_cnt_q;
  logic [PW-1:0] wr_q, rd_q;
  logic [IW-1:0] id_q [MAX_OUTST];
  logic          err_q;

  assign full = (out_cnt_q == QW'(MAX_OUTST));

  always_comb begin
    st_sel      = '0;
    st_sel.st   = 1'b1;
    st_sel.add  = st_add_i;
    st_sel.data = st_data_i;
    st_sel.be   = st_be_i;
  end

  // first requesting load at or after rr_q, cyclic
  always_comb begin
    ld_found = 1'b0;
    ld_idx   = '0;
    cand     = '0;
    for (int unsigned k = 0; k < N_LOAD; k++) begin
      cand = IW'((32'(rr_q) + k) % N_LOAD);
      if (!ld_found && ld_req_i[cand]) begin
        ld_found = 1'b1;
        ld_idx   = cand;
      end
    end
  end

  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    if (lock_q) begin
      // a stalled request is replayed unchanged, ignoring enable and competitors
      sel     = lock_sel_q;
      sel_vld = 1'b1;
    end else if (enable_i) begin
      if (st_req_i && (st_cnt_q < CW'(ST_BURST))) begin
        sel     = st_sel;
        sel_vld = 1'b1;
      end else if (ld_found && !full) begin
        sel.idx = ld_idx;
        sel.add = ld_add_i[ld_idx];
        sel_vld = 1'b1;
      end else if (st_req_i) begin
        sel     = st_sel;
        sel_vld = 1'b1;
      end
    end
  end

  assign tcdm_req_o  = sel_vld;
  assign tcdm_wen_o  = sel_vld & ~sel.st;
  assign tcdm_add_o  = sel.add;
  assign tcdm_data_o = sel.data;
  assign tcdm_be_o   = sel.be;

  assign accept   = tcdm_req_o & tcdm_gnt_i;
  assign ld_acc   = accept & ~sel.st;
  assign st_gnt_o = accept & sel.st;

  always_comb begin
    ld_gnt_o = '0;
    if (ld_acc) ld_gnt_o[sel.idx] = 1'b1;
  end

  // response routing
  assign push = ld_acc;
  assign pop  = tcdm_r_valid_i & (out_cnt_q != '0);

  always_comb begin
    ld_r_valid_o = '0;
    if (pop) ld_r_valid_o[id_q[rd_q]] = 1'b1;
  end
  assign ld_r_data_o = tcdm_r_data_i;

  assign busy_o = lock_q | (out_cnt_q != '0);
  assign err_o  = err_q;

  // FIFO payload needs no reset: it is only read while the count is nonzero
  always_ff @(posedge clk_i) begin
    if (push) id_q[wr_q] <= sel.idx;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q     <= 1'b0;
      lock_sel_q <= '0;
      rr_q       <= '0;
      st_cnt_q   <= '0;
      out_cnt_q  <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      err_q      <= 1'b0;
    end else if (clear_i) begin
      lock_q     <= 1'b0;
      lock_sel_q <= '0;
      rr_q       <= '0;
      st_cnt_q   <= '0;
      out_cnt_q  <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      err_q      <= 1'b0;
    end else begin
      if (tcdm_req_o && !tcdm_gnt_i) begin
        lock_q     <= 1'b1;
        lock_sel_q <= sel;
      end else if (accept) begin
        lock_q <= 1'b0;
      end

      if (ld_acc) rr_q <= (sel.idx == IW'(N_LOAD - 1)) ? '0 : sel.idx + 1'b1;

      if (ld_acc || (ld_req_i == '0)) st_cnt_q <= '0;
      else if (st_gnt_o && (st_cnt_q != CW'(ST_BURST))) st_cnt_q <= st_cnt_q + 1'b1;

      if (push) wr_q <= (wr_q == PW'(MAX_OUTST - 1)) ? '0 : wr_q + 1'b1;
      if (pop)  rd_q <= (rd_q == PW'(MAX_OUTST - 1)) ? '0 : rd_q + 1'b1;
      if (push && !pop)      out_cnt_q <= out_cnt_q + 1'b1;
      else if (pop && !push) out_cnt_q <= out_cnt_q - 1'b1;

      if (tcdm_r_valid_i && (out_cnt_q == '0)) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_neureka_tcdm_arbiter.sv
module tb_neureka_tcdm_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 256;
  localparam int MO = 4;
  localparam int SB = 8;

  logic clk = 0, rst_n = 0, clear_i, enable_i;
  logic [N-1:0] ld_req_i, ld_gnt_o, ld_r_valid_o;
  logic [N-1:0][AW-1:0] ld_add_i;
  logic [DW-1:0] ld_r_data_o, st_data_i, tcdm_data_o, tcdm_r_data_i;
  logic st_req_i, st_gnt_o, tcdm_req_o, tcdm_wen_o, tcdm_gnt_i, tcdm_r_valid_i, busy_o, err_o;
  logic [AW-1:0] st_add_i, tcdm_add_o;
  logic [DW/8-1:0] st_be_i, tcdm_be_o;

  always #5 clk = ~clk;

  neureka_tcdm_arbiter #(.N_LOAD(N), .AW(AW), .DW(DW), .MAX_OUTST(MO), .ST_BURST(SB)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear_i), .enable_i(enable_i),
    .ld_req_i(ld_req_i), .ld_add_i(ld_add_i), .ld_gnt_o(ld_gnt_o),
    .ld_r_valid_o(ld_r_valid_o), .ld_r_data_o(ld_r_data_o),
    .st_req_i(st_req_i), .st_add_i(st_add_i), .st_data_i(st_data_i), .st_be_i(st_be_i),
    .st_gnt_o(st_gnt_o), .tcdm_req_o(tcdm_req_o), .tcdm_wen_o(tcdm_wen_o),
    .tcdm_add_o(tcdm_add_o), .tcdm_data_o(tcdm_data_o), .tcdm_be_o(tcdm_be_o),
    .tcdm_gnt_i(tcdm_gnt_i), .tcdm_r_valid_i(tcdm_r_valid_i), .tcdm_r_data_i(tcdm_r_data_i),
    .busy_o(busy_o), .err_o(err_o));

  typedef struct {
    bit st; int idx; logic [AW-1:0] add; logic [DW-1:0] data; logic [DW/8-1:0] be;
  } tx_t;
  typedef struct { int id; logic [DW-1:0] data; } rsp_t;

  int n_chk = 0, n_fail = 0;
  tx_t  txq[$];
  rsp_t rspq[$];
  int   acc_log[$];
  int   exp_q[$];

  // reference model state
  int  m_q[$];        // ids of outstanding reads, oldest first
  int  m_rr = 0, m_cnt = 0;
  bit  m_lock = 0, m_err = 0;
  tx_t m_lk;
  bit  auto_rsp = 0, mon_en = 0;
  bit  last_acc, last_st;
  int  last_idx;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_log(input string nm);
    chk({nm, "_len"}, DW'(acc_log.size()), DW'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < acc_log.size(); k++)
      chk(nm, DW'(acc_log[k]), DW'(exp_q[k]));
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] d;
    for (int k = 0; k < DW/32; k++) d[k*32 +: 32] = $urandom;
    return d;
  endfunction

  // One clock cycle: evaluate the model on the inputs the caller set, push
  // expectations, then commit model state at the active edge.
  task automatic step();
    tx_t s; bit req, acc, pop, bad; rsp_t r;
    if (auto_rsp) begin
      tcdm_r_valid_i = (m_q.size() != 0);
      tcdm_r_data_i  = rnd_data();
    end
    #2;
    req = 0; s.st = 0; s.idx = 0; s.add = '0; s.data = '0; s.be = '0;
    if (m_lock) begin
      req = 1; s = m_lk;
    end else if (enable_i) begin
      if (st_req_i && m_cnt < SB) begin
        req = 1; s.st = 1; s.add = st_add_i; s.data = st_data_i; s.be = st_be_i;
      end else begin
        for (int k = 0; k < N; k++) begin
          int j;
          j = (m_rr + k) % N;
          if (!req && ld_req_i[j] && m_q.size() < MO) begin
            req = 1; s.idx = j; s.add = ld_add_i[j];
          end
        end
        if (!req && st_req_i) begin
          req = 1; s.st = 1; s.add = st_add_i; s.data = st_data_i; s.be = st_be_i;
        end
      end
    end
    acc = req && tcdm_gnt_i;
    last_acc = acc; last_st = s.st; last_idx = s.idx;
    if (acc) txq.push_back(s);
    pop = 0; bad = 0;
    if (tcdm_r_valid_i) begin
      if (m_q.size() != 0) begin
        pop = 1; r.id = m_q[0]; r.data = tcdm_r_data_i; rspq.push_back(r);
      end else bad = 1;
    end
    @(posedge clk);
    if (pop) void'(m_q.pop_front());
    if (acc && !s.st) begin
      m_q.push_back(s.idx);
      m_rr = (s.idx + 1) % N;
    end
    if (acc && !s.st) m_cnt = 0;
    else if (ld_req_i == '0) m_cnt = 0;
    else if (acc && s.st && m_cnt < SB) m_cnt++;
    if (req && !tcdm_gnt_i) begin m_lock = 1; m_lk = s; end
    else if (acc) m_lock = 0;
    if (bad) m_err = 1;
    if (clear_i) begin m_rr = 0; m_cnt = 0; m_q.delete(); m_lock = 0; m_err = 0; end
    @(negedge clk);
  endtask

  task automatic idle();
    clear_i = 0; enable_i = 1; ld_req_i = '0; st_req_i = 0; tcdm_gnt_i = 0;
    tcdm_r_valid_i = 0; tcdm_r_data_i = '0;
  endtask

  task automatic drain();
    logic sv;
    sv = auto_rsp; auto_rsp = 1; tcdm_gnt_i = 1;
    for (int c = 0; c < 20 && (m_q.size() != 0 || m_lock); c++) begin
      step();
      if (last_acc) begin
        if (last_st) st_req_i = 0; else ld_req_i[last_idx] = 0;
      end
    end
    auto_rsp = sv; tcdm_r_valid_i = 0; tcdm_gnt_i = 0;
  endtask

  // monitor / scoreboard
  initial forever begin
    tx_t e; rsp_t r; logic [N-1:0] eg; int ix;
    @(negedge clk); #4;
    if (mon_en) begin
      if (tcdm_req_o && tcdm_gnt_i) begin
        if (txq.size() == 0) chk("tx_unexpected", DW'(1), DW'(0));
        else begin
          e = txq.pop_front();
          eg = e.st ? '0 : N'(1) << e.idx;
          chk("tx_wen", DW'(tcdm_wen_o), DW'(!e.st));
          chk("tx_add", DW'(tcdm_add_o), DW'(e.add));
          chk("tx_ld_gnt", DW'(ld_gnt_o), DW'(eg));
          chk("tx_st_gnt", DW'(st_gnt_o), DW'(e.st));
          if (e.st) begin
            chk("tx_data", tcdm_data_o, e.data);
            chk("tx_be", DW'(tcdm_be_o), DW'(e.be));
          end
        end
        ix = -1;
        for (int i = 0; i < N; i++) if (ld_gnt_o[i]) ix = i;
        acc_log.push_back(st_gnt_o ? 100 : ix);
      end
      if (ld_r_valid_o != '0) begin
        if (rspq.size() == 0) chk("rsp_unexpected", DW'(ld_r_valid_o), DW'(0));
        else begin
          r = rspq.pop_front();
          chk("rsp_route", DW'(ld_r_valid_o), DW'(N'(1) << r.id));
          chk("rsp_data", ld_r_data_o, r.data);
        end
      end
      chk("busy", DW'(busy_o), DW'(m_q.size() != 0 || m_lock));
      chk("err", DW'(err_o), DW'(m_err));
    end
  end

  initial begin
    logic [DW-1:0] d;
    idle();
    st_add_i = '0; st_data_i = '0; st_be_i = '0;
    for (int i = 0; i < N; i++) ld_add_i[i] = AW'(32'h1000 + i * 16);
    @(negedge clk); @(negedge clk);
    // reset state
    chk("rst_req", DW'(tcdm_req_o), DW'(0));
    chk("rst_wen", DW'(tcdm_wen_o), DW'(0));
    chk("rst_add", DW'(tcdm_add_o), DW'(0));
    chk("rst_gnts", DW'({ld_gnt_o, st_gnt_o}), DW'(0));
    chk("rst_rvalid", DW'(ld_r_valid_o), DW'(0));
    chk("rst_busy_err", DW'({busy_o, err_o}), DW'(0));
    rst_n = 1; mon_en = 1;
    @(negedge clk);

    // single load
    d = rnd_data();
    ld_add_i[1] = 32'h100; ld_req_i = 4'b0010; tcdm_gnt_i = 1;
    #1 chk("single_wen", DW'(tcdm_wen_o), DW'(1));
    chk("single_gnt", DW'(ld_gnt_o), DW'(4'b0010));
    step(); ld_req_i = '0; tcdm_gnt_i = 0;
    chk("single_busy_c1", DW'(busy_o), DW'(1));
    step();
    chk("single_busy_c2", DW'(busy_o), DW'(1));
    tcdm_r_valid_i = 1; tcdm_r_data_i = d;
    #1 chk("single_rvalid", DW'(ld_r_valid_o), DW'(4'b0010));
    chk("single_rdata", ld_r_data_o, d);
    step(); tcdm_r_valid_i = 0;
    chk("single_busy_c3", DW'(busy_o), DW'(0));

    // round-robin from a cleared pointer
    clear_i = 1; step(); clear_i = 0;
    acc_log.delete(); auto_rsp = 1;
    ld_req_i = 4'b1111; tcdm_gnt_i = 1;
    repeat (5) step();
    ld_req_i = '0; drain();
    exp_q = {0, 1, 2, 3, 0}; chk_log("rr_order");

    // store priority with starvation bound
    acc_log.delete();
    st_req_i = 1; st_add_i = 32'h4000; st_data_i = rnd_data(); st_be_i = 32'hA5A5_0FF0;
    ld_req_i = 4'b0001; tcdm_gnt_i = 1;
    repeat (18) step();
    st_req_i = 0; ld_req_i = '0; drain();
    exp_q.delete();
    for (int k = 0; k < 18; k++) exp_q.push_back((k == 8 || k == 17) ? 0 : 100);
    chk_log("starve_order");

    // backpressure lock
    idle(); acc_log.delete(); auto_rsp = 1;
    ld_add_i[0] = 32'h200; ld_req_i = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) begin st_req_i = 1; st_add_i = 32'h300; st_data_i = rnd_data(); end
      #1 chk("lock_add", DW'(tcdm_add_o), DW'(32'h200));
      chk("lock_wen", DW'(tcdm_wen_o), DW'(1));
      step();
    end
    tcdm_gnt_i = 1; step(); ld_req_i = '0;
    step(); st_req_i = 0;
    drain();
    exp_q = {0, 100}; chk_log("lock_order");

    // FIFO full
    idle(); auto_rsp = 0; ld_req_i = 4'b0001; tcdm_gnt_i = 1;
    repeat (4) step();
    #1 chk("full_noreq", DW'(tcdm_req_o), DW'(0));
    step();
    st_req_i = 1; st_add_i = 32'h500; st_data_i = rnd_data();
    #1 chk("full_store_req", DW'({tcdm_req_o, tcdm_wen_o}), DW'(2'b10));
    step(); st_req_i = 0;
    tcdm_r_valid_i = 1; tcdm_r_data_i = rnd_data();
    #1 chk("full_pop_noreq", DW'(tcdm_req_o), DW'(0));
    step(); tcdm_r_valid_i = 0;
    #1 chk("full_reissue", DW'({tcdm_req_o, tcdm_wen_o}), DW'(2'b11));
    step(); ld_req_i = '0; drain();

    // enable low blocks issue in the same cycle
    idle(); enable_i = 0; ld_req_i = 4'b0001;
    #1 chk("en_low_noreq", DW'(tcdm_req_o), DW'(0));
    step(); enable_i = 1; tcdm_gnt_i = 1; step(); ld_req_i = '0; drain();

    // error and clear
    idle(); tcdm_r_valid_i = 1; tcdm_r_data_i = rnd_data();
    #1 chk("err_no_rvalid", DW'(ld_r_valid_o), DW'(0));
    step(); tcdm_r_valid_i = 0;
    chk("err_set", DW'(err_o), DW'(1));
    clear_i = 1; step(); clear_i = 0;
    chk("err_cleared", DW'(err_o), DW'(0));
    acc_log.delete(); ld_req_i = 4'b1111; tcdm_gnt_i = 1;
    step(); ld_req_i = '0; drain();
    exp_q = {0}; chk_log("clear_rr");

    // randomized traffic
    idle(); auto_rsp = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        if (!ld_req_i[i] && $urandom_range(2) == 0) begin
          ld_req_i[i] = 1; ld_add_i[i] = $urandom;
        end
      if (!st_req_i && $urandom_range(2) == 0) begin
        st_req_i = 1; st_add_i = $urandom; st_data_i = rnd_data(); st_be_i = $urandom;
      end
      tcdm_gnt_i = ($urandom_range(3) != 0);
      enable_i = ($urandom_range(7) != 0);
      if (m_q.size() != 0) tcdm_r_valid_i = 1'($urandom_range(1));
      else tcdm_r_valid_i = ($urandom_range(99) == 0);
      tcdm_r_data_i = rnd_data();
      step();
      if (last_acc) begin
        if (last_st) st_req_i = 0; else ld_req_i[last_idx] = 0;
      end
    end
    ld_req_i = '0; st_req_i = 0; enable_i = 1; drain();
    repeat (2) step();
    chk("txq_empty", DW'(txq.size()), DW'(0));
    chk("rspq_empty", DW'(rspq.size()), DW'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/neureka_tcdm_arbiter.md
# neureka_tcdm_arbiter

Shares one TCDM initiator port between the NEUREKA load streams (feat, weight, norm, streamin) and the conv store stream. Stores get priority, bounded by an anti-starvation rule; loads are served round-robin. Read responses are routed back to the issuing load through an in-order ID FIFO. The block sits between the streamer's per-stream source/sink request ports and the top-level `tcdm` port.

## Interface
- `N_LOAD`, default 4: number of load requesters (index 0 = feat, 1 = weight, 2 = norm, 3 = streamin).
- `AW`, default 32: address width.
- `DW`, default 256: data width. Must be a multiple of 8.
- `MAX_OUTST`, default 4: maximum number of outstanding reads (ID FIFO depth). Must be ≥ 2.
- `ST_BURST`, default 8: maximum consecutive store grants while any load is pending.

Ports:
- `clk_i` in 1: clock, the block's single clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `clear_i` in 1: synchronous soft clear.
- `enable_i` in 1: when low, no new transaction is issued.
- `ld_req_i` in N_LOAD: read request, one per load.
- `ld_add_i` in N_LOAD×AW: read address, one per load.
- `ld_gnt_o` out N_LOAD: read request accepted.
- `ld_r_valid_o` out N_LOAD: read data valid for that load.
- `ld_r_data_o` out DW: read data, broadcast to all loads.
- `st_req_i` in 1, `st_add_i` in AW, `st_data_i` in DW, `st_be_i` in DW/8: store request.
- `st_gnt_o` out 1: store request accepted.
- `tcdm_req_o` out 1, `tcdm_wen_o` out 1 (1 = read), `tcdm_add_o` out AW, `tcdm_data_o` out DW, `tcdm_be_o` out DW/8: TCDM request.
- `tcdm_gnt_i` in 1, `tcdm_r_valid_i` in 1, `tcdm_r_data_i` in DW: TCDM grant and response.
- `busy_o` out 1: outstanding count is nonzero or a lock is held.
- `err_o` out 1: sticky; set by an unexpected `tcdm_r_valid_i`.

## Operation
- Accept: a transaction is accepted when `tcdm_req_o & tcdm_gnt_i`. The matching `ld_gnt_o[i]` or `st_gnt_o` equals `tcdm_gnt_i` in that cycle; all other grants are 0.
- Selection when unlocked and `enable_i` = 1:
  - Store wins if `st_req_i` = 1 and the starvation counter is below `ST_BURST`.
  - Otherwise the first requesting load at or after `rr_ptr` (cyclic) wins, provided the FIFO is not full.
  - If no load is eligible, a pending store wins regardless of the counter.
- Lock: if the selected request is presented and not granted, the selection is registered. The same requester is driven next cycle with the same address, data and be, independent of other requests and of `enable_i`. The lock is released on accept.
- Requester obligation: a requester holds its req, address and data stable until granted. Violations are not checked.
- `rr_ptr` (width clog2(N_LOAD)): on a load accept from index i, it becomes (i+1) mod N_LOAD and wraps N_LOAD-1 → 0. It is unchanged otherwise.
- Starvation counter (saturating, width clog2(ST_BURST+1)):
  - +1 on a store accept while any `ld_req_i` is set.
  - Reset to 0 on any load accept, or when no load is requesting.
- ID FIFO:
  - A load accept pushes index i.
  - `tcdm_r_valid_i` pops the head h, drives `ld_r_valid_o[h]` = 1 and passes `ld_r_data_o` = `tcdm_r_data_i`.
  - Push and pop in the same cycle are both allowed; the count is unchanged.
  - Full is evaluated on the registered count, so a read is never issued while full, even if a pop occurs that cycle.
- Stores generate no response.
- A `tcdm_r_valid_i` with the FIFO empty sets `err_o`; no `ld_r_valid_o` is raised.
- `clear_i`:
  - Zeroes the pointer, counter, FIFO and lock, and clears `err_o`.
  - If reads were outstanding, their later responses hit an empty FIFO and set `err_o`. The controller asserts `clear_i` only when `busy_o` = 0.

## Timing
- Reset values: all outputs are 0; `rr_ptr`, counter, FIFO and lock are empty or zero.
- Request path is combinational, 0-cycle: `ld_req_i`/`st_req_i` → `tcdm_req_o`/`tcdm_add_o`, and `tcdm_gnt_i` → `ld_gnt_o`/`st_gnt_o`.
- Response path is combinational, 0-cycle: `tcdm_r_valid_i` → `ld_r_valid_o`. Response latency is whatever the TCDM provides (≥1 cycle), strictly in order.
- `busy_o` is registered-state based (count and lock), so it has no combinational path from inputs.
- `enable_i` low with no lock: `tcdm_req_o` = 0 in that same cycle, and the response path stays active.

## Test plan
- Single load: `ld_req_i`=4'b0010, addr 0x100, gnt=1, r_valid 2 cycles later with data D → `tcdm_wen_o`=1, `ld_gnt_o`=4'b0010, then `ld_r_valid_o`=4'b0010 with `ld_r_data_o`=D; `busy_o` high for exactly 2 cycles.
- Round-robin: `ld_req_i`=4'b1111 held, gnt always 1, responses returned → grant order 0,1,2,3,0; each response routed to the index that issued it.
- Store priority and starvation: `st_req_i`=1 and `ld_req_i`=4'b0001 both held, gnt=1 → 8 store grants, then 1 load grant, then stores again.
- Backpressure lock: `ld_req_i`=4'b0001 with gnt=0 for 3 cycles, then `st_req_i` raised in cycle 2 → `tcdm_add_o` stays at load 0's address and its grant comes first; the store is granted next cycle.
- FIFO full: MAX_OUTST=4, 4 reads accepted with no response → 5th load not issued (`tcdm_req_o`=0); a pending store is still issued; after 1 r_valid, the load issues the next cycle.
- Error and clear: r_valid with no outstanding read → `err_o`=1, `ld_r_valid_o`=0; `clear_i` pulse → `err_o`=0 and `rr_ptr`=0, so the next grant with `ld_req_i`=4'b1111 goes to index 0.
